// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_pkg
//  Purpose  : Shared types and constants for the 4x4 hex keypad scanner:
//             FSM state encoding, per-scan result encoding and key map.
//  Revision : 1.0  initial release
// ============================================================================
package keypad_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } kp_state_e;

   typedef enum logic [1:0] {
      NONE   = 2'd0,
      SINGLE = 2'd1,
      MULTI  = 2'd2
   } scan_res_e;

   // Indexed by {row, col}; entry 0 is row 0 / column 0.
   localparam logic [15:0][3:0] KEY_MAP = {
      4'hD, 4'hF, 4'h0, 4'hE,   // row 3
      4'hC, 4'h9, 4'h8, 4'h7,   // row 2
      4'hB, 4'h6, 4'h5, 4'h4,   // row 1
      4'hA, 4'h3, 4'h2, 4'h1    // row 0
   };

   function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
      return KEY_MAP[{row, col}];
   endfunction

endpackage
`default_nettype wire

// File: rtl/kp_scan_tick.sv
`default_nettype none
// ============================================================================
//  Module   : kp_scan_tick
//  Purpose  : Free-running prescaler plus 4-phase row rotator. Produces a
//             tick on the last prescaler count and an active-low one-cold
//             row drive; shared with the display digit multiplexer.
//  Revision : 1.0  initial release
// ============================================================================
module kp_scan_tick #(
   parameter int SCAN_DIV_W = 15
) (
   input  logic       clk,
   input  logic       rst,
   output logic       tick_o,
   output logic [1:0] row_idx_o,
   output logic [3:0] row_n_o
);

   logic [SCAN_DIV_W-1:0] div_q;
   logic [1:0]            row_q;

   // Prescaler wraps freely; the row advances on the tick edge so each row
   // is driven for a full prescaler period before it is sampled.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= '0;
         row_q <= 2'd0;
      end else begin
         div_q <= div_q + 1'b1;
         if (tick_o) begin
            row_q <= row_q + 2'd1;
         end
      end
   end

   assign tick_o    = &div_q;
   assign row_idx_o = row_q;
   assign row_n_o   = ~(4'b0001 << row_q);

endmodule
`default_nettype wire

// File: rtl/keypad4x4_scan.sv
`default_nettype none
// ============================================================================
//  Module   : keypad4x4_scan
//  Purpose  : Scans a 4x4 hex keypad, debounces whole-matrix scan results and
//             shifts each accepted key nibble into a 32-bit value register.
//  Revision : 1.0  initial release
// ============================================================================
module keypad4x4_scan
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV_W     = 15,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cs,
   input  logic        clr,
   input  logic [3:0]  i_col,
   output logic [3:0]  o_row,
   output logic [31:0] o_data,
   output logic [3:0]  o_key,
   output logic        o_valid,
   output logic        o_pending
);

   localparam logic [3:0] c_DEB = 4'(DEBOUNCE_SCANS);

   logic       tick;
   logic [1:0] row_idx;

   kp_scan_tick #(
      .SCAN_DIV_W (SCAN_DIV_W)
   ) u_tick (
      .clk       (clk),
      .rst       (rst),
      .tick_o    (tick),
      .row_idx_o (row_idx),
      .row_n_o   (o_row)
   );

   // Scan accumulator and FSM state
   logic [1:0] acc_cnt_q, acc_cnt_d;
   logic [3:0] acc_code_q, acc_code_d;
   kp_state_e  state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] cand_q, cand_d;

   // Output-side registers
   logic [31:0] data_q;
   logic [3:0]  key_q;
   logic        valid_q;
   logic        pending_q;

   logic [1:0] row_hits;
   logic [1:0] row_col;
   logic [2:0] hit_sum;
   logic       scan_done;
   scan_res_e  res;
   logic       accept;
   logic [3:0] acc_key;

   // Decode the current row's columns: hit count (saturating at 2) and the
   // column of the last hit.
   always_comb begin
      row_hits = 2'd0;
      row_col  = 2'd0;
      for (int c = 0; c < 4; c++) begin
         if (!i_col[c]) begin
            if (row_hits != 2'd2) begin
               row_hits = row_hits + 2'd1;
            end
            row_col = 2'(c);
         end
      end
   end

   // Fold this row into the scan; row 0 starts a fresh accumulation.
   always_comb begin
      hit_sum    = (row_idx == 2'd0) ? {1'b0, row_hits} : ({1'b0, acc_cnt_q} + {1'b0, row_hits});
      acc_cnt_d  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
      acc_code_d = (row_idx == 2'd0) ? 4'h0 : acc_code_q;
      if (row_hits != 2'd0) begin
         acc_code_d = key_code(row_idx, row_col);
      end
      scan_done = tick && (row_idx == 2'd3);
      res = NONE;
      if (acc_cnt_d == 2'd1) begin
         res = SINGLE;
      end else if (acc_cnt_d == 2'd2) begin
         res = MULTI;
      end
   end

   // Debounce FSM next state; acts only on completed scans.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cand_d  = cand_q;
      accept  = 1'b0;
      acc_key = cand_q;
      if (scan_done) begin
         case (state_q)
            IDLE: begin
               if (res == SINGLE) begin
                  cand_d = acc_code_d;
                  if (c_DEB == 4'd1) begin
                     accept  = 1'b1;
                     acc_key = acc_code_d;
                     state_d = HELD;
                     cnt_d   = 4'd0;
                  end else begin
                     state_d = DEBOUNCE;
                     cnt_d   = 4'd1;
                  end
               end
            end
            DEBOUNCE: begin
               if (res == SINGLE && acc_code_d == cand_q) begin
                  if (cnt_q + 4'd1 == c_DEB) begin
                     accept  = 1'b1;
                     state_d = HELD;
                     cnt_d   = 4'd0;
                  end else begin
                     cnt_d = cnt_q + 4'd1;
                  end
               end else begin
                  state_d = IDLE;
                  cnt_d   = 4'd0;
               end
            end
            HELD: begin
               if (res == NONE) begin
                  if (c_DEB == 4'd1) begin
                     state_d = IDLE;
                     cnt_d   = 4'd0;
                  end else begin
                     state_d = RELEASE;
                     cnt_d   = 4'd1;
                  end
               end
            end
            RELEASE: begin
               if (res == NONE) begin
                  if (cnt_q + 4'd1 == c_DEB) begin
                     state_d = IDLE;
                     cnt_d   = 4'd0;
                  end else begin
                     cnt_d = cnt_q + 4'd1;
                  end
               end else begin
                  state_d = HELD;
                  cnt_d   = 4'd0;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end
         endcase
      end
   end

   // Scan accumulator and FSM registers; the candidate code needs no reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_cnt_q  <= 2'd0;
         acc_code_q <= 4'h0;
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
      end else begin
         if (tick) begin
            acc_cnt_q  <= acc_cnt_d;
            acc_code_q <= acc_code_d;
         end
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
      cand_q <= cand_d;
   end

   // Data register and handshake; clr overrides a coincident accept, and a
   // new key overrides a coincident cs.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q    <= 32'h0;
         key_q     <= 4'h0;
         valid_q   <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         valid_q <= accept && !clr;
         if (clr) begin
            data_q    <= 32'h0;
            pending_q <= 1'b0;
         end else if (accept) begin
            data_q    <= {data_q[27:0], acc_key};
            key_q     <= acc_key;
            pending_q <= 1'b1;
         end else if (cs) begin
            pending_q <= 1'b0;
         end
      end
   end

   assign o_data    = data_q;
   assign o_key     = key_q;
   assign o_valid   = valid_q;
   assign o_pending = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad4x4_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad4x4_scan
//  Purpose  : Self-checking bench for keypad4x4_scan with a keypad model,
//             a scan-level behavioural reference and directed scenarios.
//  Revision : 1.0  initial release
// ============================================================================
module tb_keypad4x4_scan;

   localparam int W    = 2;
   localparam int DEB  = 2;
   localparam int PER  = 1 << W;
   localparam int SCAN = 4 * PER;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cs  = 1'b0;
   logic        clr = 1'b0;
   logic [3:0]  i_col;
   logic [3:0]  o_row;
   logic [31:0] o_data;
   logic [3:0]  o_key;
   logic        o_valid;
   logic        o_pending;

   // Pressed switches, bit index = row*4 + col
   logic [15:0] pressed = 16'h0;

   int npass = 0;
   int ntot  = 0;
   int vcnt  = 0;

   // Keypad legend, row-major, columns left to right
   int legend [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

   // Reference model state
   bit          started = 1'b0;
   int          cyc     = 0;
   int          codes[$];
   int          streak  = 0;
   int          skey    = 0;
   bit          locked  = 1'b0;
   int          nstreak = 0;
   logic [31:0] e_data  = 32'h0;
   logic [3:0]  e_key   = 4'h0;
   logic        e_valid = 1'b0;
   logic        e_pend  = 1'b0;

   keypad4x4_scan #(
      .SCAN_DIV_W     (W),
      .DEBOUNCE_SCANS (DEB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cs        (cs),
      .clr       (clr),
      .i_col     (i_col),
      .o_row     (o_row),
      .o_data    (o_data),
      .o_key     (o_key),
      .o_valid   (o_valid),
      .o_pending (o_pending)
   );

   always #5 clk = ~clk;

   // Passive switch matrix: a pressed switch pulls its column low while its
   // row is driven low.
   always_comb begin
      i_col = 4'hF;
      for (int r = 0; r < 4; r++) begin
         if (!o_row[r]) begin
            i_col = i_col & ~pressed[r*4 +: 4];
         end
      end
   end

   function automatic int pos_of(input int code);
      for (int i = 0; i < 16; i++) begin
         if (legend[i] == code) return i;
      end
      return 0;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      ntot++;
      if (act === exp) begin
         npass++;
      end else begin
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the reference by one clock edge using the inputs the DUT will
   // sample at that edge.
   task automatic step();
      bit acc;
      int akey;
      int r;
      bit single;
      bit none;
      acc  = 1'b0;
      akey = 0;
      if (rst) begin
         started = 1'b1;
         cyc     = 0;
         codes.delete();
         streak  = 0;
         skey    = 0;
         locked  = 1'b0;
         nstreak = 0;
         e_data  = 32'h0;
         e_key   = 4'h0;
         e_valid = 1'b0;
         e_pend  = 1'b0;
         return;
      end
      if (!started) return;
      r = (cyc / PER) % 4;
      if (cyc % PER == PER - 1) begin
         if (r == 0) codes.delete();
         for (int c = 0; c < 4; c++) begin
            if (pressed[r*4 + c]) codes.push_back(legend[r*4 + c]);
         end
         if (r == 3) begin
            single = (codes.size() == 1);
            none   = (codes.size() == 0);
            if (!locked) begin
               if (streak == 0) begin
                  if (single) begin
                     skey   = codes[0];
                     streak = 1;
                  end
               end else if (single && codes[0] == skey) begin
                  streak++;
               end else begin
                  streak = 0;
               end
               if (streak != 0 && streak == DEB) begin
                  acc     = 1'b1;
                  akey    = skey;
                  locked  = 1'b1;
                  nstreak = 0;
                  streak  = 0;
               end
            end else begin
               if (none) begin
                  nstreak++;
                  if (nstreak == DEB) begin
                     locked  = 1'b0;
                     nstreak = 0;
                  end
               end else begin
                  nstreak = 0;
               end
            end
         end
      end
      e_valid = acc && !clr;
      if (clr) begin
         e_data = 32'h0;
         e_pend = 1'b0;
      end else if (acc) begin
         e_data = {e_data[27:0], 4'(akey)};
         e_key  = 4'(akey);
         e_pend = 1'b1;
      end else if (cs) begin
         e_pend = 1'b0;
      end
      cyc++;
   endtask

   // Per-cycle comparison against the reference, then advance it.
   initial begin
      logic [3:0] e_row;
      forever begin
         @(negedge clk);
         if (started) begin
            e_row = ~(4'b0001 << ((cyc / PER) % 4));
            check("cycle", {22'h0, o_row, o_data, o_key, o_valid, o_pending},
                           {22'h0, e_row, e_data, e_key, e_valid, e_pend});
            if (o_valid === 1'b1) vcnt++;
         end
         step();
      end
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic align(input int m);
      int n;
      n = 0;
      while (cyc % SCAN != m && n < 4 * SCAN) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (cyc % SCAN != m) begin
         ntot++;
         $display("FAIL align: phase %0d expected %0d", cyc % SCAN, m);
      end
   endtask

   task automatic key_in(input int code);
      align(0);
      pressed = 16'h1 << pos_of(code);
      cycles(DEB * SCAN);
      pressed = 16'h0;
      cycles(DEB * SCAN);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      cycles(3);
      rst = 1'b0;

      // Idle after reset
      check("rst_row", {60'h0, o_row}, 64'hE);
      check("rst_data", {32'h0, o_data}, 64'h0);
      cycles(2 * SCAN);
      check("idle_valid", 64'(vcnt), 64'd0);

      // Key 6 held three scans: one accept at end of scan 2
      align(0);
      pressed = 16'h1 << 6;
      cycles(3 * SCAN);
      check("k6_vcnt", 64'(vcnt), 64'd1);
      check("k6_key", {60'h0, o_key}, 64'h6);
      check("k6_data", {32'h0, o_data}, 64'h6);
      check("k6_pend", {63'h0, o_pending}, 64'h1);
      pressed = 16'h0;
      cycles(DEB * SCAN);

      // Keys 1..9, oldest nibbles wrap out
      for (int k = 1; k <= 9; k++) key_in(k);
      check("seq_data", {32'h0, o_data}, 64'h23456789);
      check("seq_vcnt", 64'(vcnt), 64'd10);

      // One-scan bounce on 5, then a real press of 5
      align(0);
      pressed = 16'h1 << pos_of(5);
      cycles(SCAN);
      pressed = 16'h0;
      cycles(DEB * SCAN);
      check("bounce_vcnt", 64'(vcnt), 64'd10);
      key_in(5);
      check("k5_key", {60'h0, o_key}, 64'h5);
      check("k5_data", {32'h0, o_data}, 64'h34567895);

      // 0 and A together never accepted; 3 ignored while 0 held
      align(0);
      pressed = (16'h1 << pos_of(0)) | (16'h1 << pos_of(10));
      cycles(4 * SCAN);
      pressed = 16'h0;
      cycles(DEB * SCAN);
      check("multi_vcnt", 64'(vcnt), 64'd11);
      pressed = 16'h1 << pos_of(0);
      cycles(2 * SCAN);
      pressed = pressed | (16'h1 << pos_of(3));
      cycles(2 * SCAN);
      pressed = 16'h1 << pos_of(3);
      cycles(3 * SCAN);
      pressed = 16'h0;
      cycles(DEB * SCAN);
      check("held_vcnt", 64'(vcnt), 64'd12);
      check("held_key", {60'h0, o_key}, 64'h0);

      // cs read clears pending
      cs = 1'b1;
      cycles(1);
      cs = 1'b0;
      check("cs_pend", {63'h0, o_pending}, 64'h0);

      // cs on the accept edge: new key wins
      align(0);
      pressed = 16'h1 << pos_of(7);
      cycles(2 * SCAN - 1);
      cs = 1'b1;
      cycles(1);
      cs = 1'b0;
      check("cs_acc_pend", {63'h0, o_pending}, 64'h1);
      check("cs_acc_valid", {63'h0, o_valid}, 64'h1);
      check("cs_acc_key", {60'h0, o_key}, 64'h7);
      pressed = 16'h0;
      cycles(DEB * SCAN);

      // cs and clr together
      cs  = 1'b1;
      clr = 1'b1;
      cycles(1);
      cs  = 1'b0;
      clr = 1'b0;
      check("csclr_pend", {63'h0, o_pending}, 64'h0);
      check("csclr_data", {32'h0, o_data}, 64'h0);

      // clr on the accept edge: clr wins, key consumed
      align(0);
      pressed = 16'h1 << pos_of(8);
      cycles(2 * SCAN - 1);
      clr = 1'b1;
      cycles(1);
      clr = 1'b0;
      check("clr_acc_data", {32'h0, o_data}, 64'h0);
      check("clr_acc_pend", {63'h0, o_pending}, 64'h0);
      check("clr_acc_valid", {63'h0, o_valid}, 64'h0);
      check("clr_acc_key", {60'h0, o_key}, 64'h7);
      cycles(2 * SCAN);
      check("clr_acc_vcnt", 64'(vcnt), 64'd13);
      pressed = 16'h0;
      cycles(DEB * SCAN);

      // Reset mid-debounce with key still held: full debounce again
      align(0);
      pressed = 16'h1 << pos_of(9);
      cycles(SCAN + 4);
      rst = 1'b1;
      cycles(1);
      rst = 1'b0;
      check("mid_rst_row", {60'h0, o_row}, 64'hE);
      check("mid_rst_key", {60'h0, o_key}, 64'h0);
      check("mid_rst_pend", {63'h0, o_pending}, 64'h0);
      check("mid_rst_valid", {63'h0, o_valid}, 64'h0);
      cycles(SCAN);
      check("mid_rst_vcnt", 64'(vcnt), 64'd13);
      cycles(SCAN);
      check("mid_rst_k9", {60'h0, o_key}, 64'h9);
      check("mid_rst_d9", {32'h0, o_data}, 64'h9);
      pressed = 16'h0;
      cycles(DEB * SCAN);
      check("final_vcnt", 64'(vcnt), 64'd14);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/keypad4x4_scan.md
Name: keypad4x4_scan

Overview:
- Input-side companion to the 8-digit hex display driver: scans a 4x4 matrix hex keypad, debounces it, and shifts each accepted key's nibble into a 32-bit value register.
- Memory-mapped peripheral next to the display; the CPU reads o_data/o_pending and acknowledges with cs.
- Row drive is time-multiplexed active-low, matching the display's digit-select scheme.

Parameters:
SCAN_DIV_W, 15, row-advance tick every 2^SCAN_DIV_W clk cycles (sim: 2)
DEBOUNCE_SCANS, 4, consecutive full scans required to accept a press or confirm a release (range 1..15)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cs  in  1  read acknowledge; clears o_pending
clr  in  1  clear o_data and o_pending
i_col  in  4  column sense, active-low, i_col[c] = column c, externally pulled up
o_row  out  4  row drive, active-low one-cold, o_row[r] = row r
o_data  out  32  accumulated hex value, newest key in [3:0]
o_key  out  4  last accepted key code
o_valid  out  1  one-cycle pulse per accepted key
o_pending  out  1  key accepted since last cs

Behaviour:
- Reset values: prescaler 0, row index 0, o_row=4'b1110, o_data=0, o_key=0, o_valid=0, o_pending=0, state IDLE, debounce count 0, scan accumulator cleared. All other state is held.
- Prescaler: SCAN_DIV_W-bit counter, free-running. tick=1 in the cycle the counter is all-ones.
- On a tick cycle:
  - i_col is sampled for the current row r.
  - The row index increments mod 4 at that edge, so o_row changes the cycle after the tick.
  - Each row is driven for the full 2^SCAN_DIV_W cycles before it is sampled.
- Scan accumulator:
  - Row 0 sample initialises it; rows 1-3 accumulate.
  - It holds a hit count (saturating at 2) and the code of the last hit.
  - A scan completes on the tick that samples row 3.
  - Scan result: NONE (0 hits), SINGLE(K) (exactly 1), MULTI (2 or more).
- Key map (row, col0..col3):
  - r0 = 1,2,3,A
  - r1 = 4,5,6,B
  - r2 = 7,8,9,C
  - r3 = E,0,F,D
- FSM. Evaluated only at scan completion; otherwise it holds.
  - IDLE: SINGLE(K) -> DEBOUNCE, cand=K, cnt=1 (if DEBOUNCE_SCANS=1, accept immediately). Otherwise stay.
  - DEBOUNCE: SINGLE(cand) -> cnt+1; when cnt reaches DEBOUNCE_SCANS, accept and go to HELD. Any other result -> IDLE, cnt=0.
  - HELD: NONE -> RELEASE, cnt=1. SINGLE/MULTI -> stay. No auto-repeat; a second key pressed while one is held is ignored.
  - RELEASE: NONE -> cnt+1; when cnt reaches DEBOUNCE_SCANS -> IDLE. Any key -> HELD, cnt=0.
- Accept action, at the scan-completion edge:
  - o_data <= {o_data[27:0], K}, so the oldest nibble falls off (wrap after 8 keys).
  - o_key <= K; o_pending <= 1.
  - o_valid is high for exactly the one following cycle.
- Simultaneous events:
  - accept and cs in the same cycle: o_pending ends 1 (the new key wins).
  - accept and clr in the same cycle: clr wins. o_data=0, o_pending=0, o_valid stays 0, o_key is unchanged, and the FSM still moves to HELD (the key is consumed).
  - cs and clr in the same cycle: both clear o_pending.
- rst mid-scan or mid-debounce: everything returns to reset values at the next edge. A key still held after reset must pass a full debounce again.
- MULTI never produces a key, in any state.

Decomposition:
- Package keypad_pkg holds:
  - state enum {IDLE, DEBOUNCE, HELD, RELEASE}
  - KEY_MAP constant: 16 x 4-bit entries indexed {row,col}
  - scan-result encoding NONE/SINGLE/MULTI
- Sub-module kp_scan_tick: prescaler plus row rotator. It outputs tick, row index and o_row, and is reusable by the display driver.
- The FSM, scan accumulator and data register stay in keypad4x4_scan.

Test Plan (SCAN_DIV_W=2, DEBOUNCE_SCANS=2; one scan = 16 cycles):
1. Reset, no keys -> o_row steps 1110,1101,1011,0111 every 4 cycles; o_data=0; o_valid never asserts.
2. Hold row1/col2 (i_col=1011 while o_row=1101) for 3 scans -> exactly one o_valid at the end of scan 2; o_key=6; o_data=0x00000006; o_pending=1.
3. Enter 1,2,3,4,5,6,7,8,9, each with a 2-scan release between keys -> o_data=0x23456789 (the 1 has wrapped out); nine o_valid pulses total.
4. Press 5 for one scan only (bounce), then release -> no o_valid; FSM back in IDLE.
5. Hold 0 and A together for 4 scans -> no accept. Then hold 0 held while pressing 3 -> only the 0 is accepted; no accept for 3 until both are released.
6. Time cs to the accept cycle -> o_pending stays 1. Time clr to the accept cycle -> o_data=0, o_pending=0, o_valid=0. Assert rst mid-DEBOUNCE -> all outputs return to reset values.
